// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : word width, opcode field, reset PC and shared fetch types
// Revision       : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input word_t instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : DEPTH x WIDTH synchronous FIFO with flush, full/empty and count
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]    PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_next(wr_q);
      if (do_pop)  rd_q <= ptr_next(rd_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked solely by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (!(push_i && full_o));
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : credit-based instruction fetch with in-order memory responses,
//              redirect handling and a drain state for stale responses
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [WORD_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc,
  output logic [3:0]        if_opcode
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  fetch_state_e     state_q, state_d;
  word_t            fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] drop_base;

  fetch_entry_t     push_entry, head_entry;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic [CNT_W:0]   credit_used;
  logic             pop, push, req_fire;

  assign if_valid   = !rst && !fifo_empty;
  assign if_instr   = head_entry.instr;
  assign if_pc      = head_entry.pc;
  assign if_opcode  = opcode_of(head_entry.instr);

  assign pop  = if_valid && if_ready && !redirect_valid;
  assign push = (state_q == ST_RUN) && imem_rsp_valid && !redirect_valid;

  // A same-cycle pop frees its slot, which keeps a 1-cycle memory streaming.
  assign credit_used    = {1'b0, out_q} + {1'b0, fifo_cnt} - {{CNT_W{1'b0}}, pop};
  assign imem_req_valid = !rst && (state_q == ST_RUN) && !redirect_valid &&
                          !(fifo_full && !pop) && (credit_used < CREDIT_LIMIT);
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Outstanding PCs are contiguous, so the oldest one sits out_q behind fetch_pc.
  assign push_entry.pc    = fetch_pc_q - WORD_W'(out_q);
  assign push_entry.instr = imem_rsp_data;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t)),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    drop_base  = (state_q == ST_RUN) ? out_q : drop_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      out_d      = '0;
      drop_d     = (imem_rsp_valid && (drop_base != '0)) ? drop_base - CNT_ONE : drop_base;
      state_d    = (drop_d != '0) ? ST_DRAIN : ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 16'd1;
      out_d = out_q + CNT_W'(req_fire) - CNT_W'(push);
    end else begin
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_ONE;
      if (drop_d == '0) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed bench for fetch_unit with a latency-selectable memory
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_ready = 1'b1;
  logic        redir_v = 1'b0;
  logic [15:0] redir_pc = 16'h0000;
  logic        if_ready = 1'b1;
  logic [1:0]  lsel = 2'd0;

  wire         imem_req_valid;
  wire  [15:0] imem_addr;
  wire         imem_rsp_valid;
  wire  [15:0] imem_rsp_data;
  wire         if_valid;
  wire  [15:0] if_instr;
  wire  [15:0] if_pc;
  wire  [3:0]  if_opcode;

  wire         w_req_valid;
  wire  [15:0] w_addr;
  wire         w_if_valid;
  wire  [15:0] w_if_instr;
  wire  [15:0] w_if_pc;
  wire  [3:0]  w_if_opcode;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redir_v),
    .redirect_pc    (redir_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (req_ready),
    .imem_addr      (w_addr),
    .imem_rsp_valid (1'b0),
    .imem_rsp_data  (16'h0000),
    .redirect_valid (1'b0),
    .redirect_pc    (16'h0000),
    .if_valid       (w_if_valid),
    .if_ready       (1'b0),
    .if_instr       (w_if_instr),
    .if_pc          (w_if_pc),
    .if_opcode      (w_if_opcode)
  );

  // Memory: response lsel+1 cycles after the handshake, data = addr ^ B000.
  logic [3:0]  s_v;
  logic [15:0] s_a [4];
  int          nreq;

  always @(posedge clk) begin
    if (rst) begin
      s_v  <= '0;
      nreq <= 0;
    end else begin
      s_v    <= {s_v[2:0], imem_req_valid && req_ready};
      s_a[0] <= imem_addr;
      for (int i = 1; i < 4; i++) s_a[i] <= s_a[i-1];
      if (imem_req_valid && req_ready) nreq <= nreq + 1;
    end
  end

  assign imem_rsp_valid = s_v[lsel];
  assign imem_rsp_data  = s_a[lsel] ^ 16'hB000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    // Reset release, 1-cycle memory, decode always ready; wrap instance alongside.
    step();
    step();
    settle();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid",  32'(if_valid),       32'd0);
    chk("rst_w_req",     32'(w_req_valid),    32'd0);
    rst = 1'b0;
    settle();
    chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c0_addr",      32'(imem_addr),      32'h0000);
    chk("c0_w_addr",    32'(w_addr),         32'hFFFF);
    chk("c0_if_valid",  32'(if_valid),       32'd0);
    step();
    chk("c1_addr",      32'(imem_addr),      32'h0001);
    chk("c1_w_addr",    32'(w_addr),         32'h0000);
    chk("c1_w_req",     32'(w_req_valid),    32'd1);
    chk("c1_if_valid",  32'(if_valid),       32'd0);
    for (int k = 2; k < 6; k++) begin
      step();
      chk("stream_req_valid", 32'(imem_req_valid), 32'd1);
      chk("stream_addr",      32'(imem_addr),      32'(k));
      chk("stream_if_valid",  32'(if_valid),       32'd1);
      chk("stream_if_pc",     32'(if_pc),          32'(k - 2));
      chk("stream_if_instr",  32'(if_instr),       32'(k - 2) ^ 32'hB000);
      chk("stream_opcode",    32'(if_opcode),      32'hB);
    end

    // Decode stalled for five cycles: only two requests fit.
    if_ready = 1'b0;
    do_reset();
    chk("st_c0_req", 32'(imem_req_valid), 32'd1);
    step();
    chk("st_c1_addr", 32'(imem_addr), 32'h0001);
    step();
    chk("st_c2_req",   32'(imem_req_valid), 32'd0);
    chk("st_c2_ifpc",  32'(if_pc),          32'h0000);
    step();
    step();
    chk("st_c4_req",   32'(imem_req_valid), 32'd0);
    chk("st_c4_nreq",  32'(nreq),           32'd2);
    chk("st_c4_ifpc",  32'(if_pc),          32'h0000);
    step();
    if_ready = 1'b1;
    settle();
    chk("st_c5_req",   32'(imem_req_valid), 32'd1);
    chk("st_c5_addr",  32'(imem_addr),      32'h0002);
    chk("st_c5_ifpc",  32'(if_pc),          32'h0000);
    step();
    chk("st_c6_ifpc",  32'(if_pc),          32'h0001);
    chk("st_c6_instr", 32'(if_instr),       32'hB001);

    // 3-cycle memory, two outstanding, redirect to 0040.
    lsel = 2'd2;
    do_reset();
    chk("dr_c0_addr", 32'(imem_addr), 32'h0000);
    step();
    chk("dr_c1_addr", 32'(imem_addr), 32'h0001);
    step();
    redir_v  = 1'b1;
    redir_pc = 16'h0040;
    settle();
    chk("dr_c2_req", 32'(imem_req_valid), 32'd0);
    step();
    redir_v = 1'b0;
    settle();
    chk("dr_c3_req",   32'(imem_req_valid), 32'd0);
    chk("dr_c3_ifv",   32'(if_valid),       32'd0);
    step();
    chk("dr_c4_req",   32'(imem_req_valid), 32'd0);
    chk("dr_c4_ifv",   32'(if_valid),       32'd0);
    step();
    chk("dr_c5_req",   32'(imem_req_valid), 32'd1);
    chk("dr_c5_addr",  32'(imem_addr),      32'h0040);
    chk("dr_c5_ifv",   32'(if_valid),       32'd0);
    step();
    step();
    step();
    chk("dr_c8_ifv",   32'(if_valid),       32'd0);
    step();
    chk("dr_c9_ifv",   32'(if_valid),       32'd1);
    chk("dr_c9_ifpc",  32'(if_pc),          32'h0040);
    chk("dr_c9_instr", 32'(if_instr),       32'hB040);

    // Redirect colliding with a pop and a response, 1-cycle memory.
    lsel = 2'd0;
    do_reset();
    step();
    step();
    redir_v  = 1'b1;
    redir_pc = 16'h0080;
    settle();
    chk("rc_c2_ifv", 32'(if_valid), 32'd1);
    step();
    redir_v = 1'b0;
    settle();
    chk("rc_c3_ifv",  32'(if_valid),       32'd0);
    chk("rc_c3_req",  32'(imem_req_valid), 32'd1);
    chk("rc_c3_addr", 32'(imem_addr),      32'h0080);
    step();
    chk("rc_c4_ifv",  32'(if_valid),       32'd0);
    chk("rc_c4_addr", 32'(imem_addr),      32'h0081);
    step();
    chk("rc_c5_ifpc",  32'(if_pc),         32'h0080);
    chk("rc_c5_instr", 32'(if_instr),      32'hB080);

    // Reset while draining two stale responses.
    lsel = 2'd2;
    do_reset();
    step();
    step();
    redir_v  = 1'b1;
    redir_pc = 16'h0040;
    settle();
    step();
    redir_v = 1'b0;
    rst     = 1'b1;
    settle();
    chk("rd_c3_req", 32'(imem_req_valid), 32'd0);
    chk("rd_c3_ifv", 32'(if_valid),       32'd0);
    step();
    rst = 1'b0;
    settle();
    chk("rd_c4_req",  32'(imem_req_valid), 32'd1);
    chk("rd_c4_addr", 32'(imem_addr),      32'h0000);
    chk("rd_c4_ifv",  32'(if_valid),       32'd0);
    step();
    chk("rd_c5_addr", 32'(imem_addr),      32'h0001);
    chk("rd_c5_ifv",  32'(if_valid),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
